captura_numero: RTL
===================

Name: captura_numero

Overview:
- Upstream stage of the number-storage block (Guardado_datos).
- Turns debounced keypad events into a 4-digit packed BCD number, shifting each new digit in from the right.
- On an operator key (suma / igual) it presents the completed number and issues a one-cycle guardar strobe, with a matching suma flag, that the storage block samples on the same edge.

Parameters:
- NUM_DIGITOS, 4, number of BCD digits captured; the numero width is 4*NUM_DIGITOS.
- TECLA_SUMA, 4'hA, key code for '+': save the number with suma=1.
- TECLA_IGUAL, 4'hB, key code for '=': save the number with suma=0.
- TECLA_BORRAR, 4'hC, key code for clear.
- TIMEOUT_CICLOS, 50_000_000, idle cycles before entry is auto-cleared. Used only with CAPTURA_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-low reset.
- tecla_valida  input  1  one-cycle pulse: tecla holds a new key code.
- tecla  input  4  key code: 0-9 are digits; A, B, C as set by the parameters; D-F are ignored.
- numero  output  [NUM_DIGITOS-1:0][3:0]  packed BCD number. [NUM_DIGITOS-1] is the most significant digit.
- guardar  output  1  one-cycle save strobe, to Guardado_datos.guardar.
- suma  output  1  valid only while guardar=1. 1 = '+' key, 0 = '=' key.
- conteo  output  $clog2(NUM_DIGITOS+1)  number of digits entered.
- desborde  output  1  sticky: a digit arrived while the entry was full.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a posedge) sets numero=0, guardar=0, suma=0, conteo=0, desborde=0 and state=ESPERA.
- Reset overrides every other input on the same edge, including in mid-capture or during GUARDA.

States:
- ESPERA: conteo=0.
- CAPTURA: 0<conteo<NUM_DIGITOS.
- LLENO: conteo=NUM_DIGITOS.
- GUARDA: lasts exactly one cycle.

Digit key (tecla<=9) in ESPERA or CAPTURA:
- numero <= {numero[NUM_DIGITOS-2:0], tecla}, conteo+1.
- Next state is CAPTURA, or LLENO once conteo reaches NUM_DIGITOS.
- Leading zeros count as digits.
- Digit key in LLENO: numero and conteo unchanged, desborde <= 1.

TECLA_SUMA or TECLA_IGUAL:
- With conteo>0, go to GUARDA. During that cycle guardar=1, suma=(key==TECLA_SUMA), and numero holds the final value.
- On the following edge: numero=0, conteo=0, desborde=0, guardar=0, suma=0, state=ESPERA.
- With conteo=0 the key is ignored and no strobe is issued.

TECLA_BORRAR:
- From ESPERA, CAPTURA or LLENO: numero=0, conteo=0, desborde=0, state=ESPERA.

Other cases:
- Any key while in GUARDA is dropped, including clear.
- Codes D-F are ignored in every state.
- tecla_valida=0: hold all state.
- Latency: a key pulse at edge N is reflected on the outputs after edge N. guardar is high for the cycle following edge N.

Optional Feature:
- Macro: CAPTURA_TIMEOUT_EN.
- Defined:
  - An idle counter runs while in CAPTURA or LLENO.
  - It resets to 0 on every tecla_valida and whenever the state is ESPERA or GUARDA.
  - When it reaches TIMEOUT_CICLOS-1, the next edge behaves exactly like TECLA_BORRAR. No guardar is issued.
  - A key arriving on that same edge takes precedence, and the counter restarts.
- Not defined: no counter is built, entry persists indefinitely, and TIMEOUT_CICLOS is unused.

Test Plan:
1. Keys 2,1,6,5 then A -> numero=16'h2165 and conteo=4 before A. Next cycle guardar=1, suma=1, numero=16'h2165 for exactly one cycle. Then numero=0, conteo=0.
2. Keys 9,3,4,1,7 then B -> numero stays 16'h9341 and desborde=1 after 7. B gives guardar=1, suma=0, numero=16'h9341; afterwards desborde=0.
3. A with conteo=0 -> guardar is never asserted and all outputs stay 0. Then keys 0,0,3 followed by A -> guardar with numero=16'h0003.
4. Keys 5,8 then C -> numero=0, conteo=0, state ESPERA. A key E mid-entry -> no change.
5. Keys 4,2 then rst=0 for one cycle; in a second run, rst=0 during the GUARDA cycle -> all outputs 0 on the next edge, and no second guardar.
6. With CAPTURA_TIMEOUT_EN and TIMEOUT_CICLOS=8: key 7, then idle for 8 cycles -> numero=0, conteo=0, and no guardar. A key at cycle 7 instead restarts the count and keeps 16'h0007.

Source files
------------

// File: rtl/captura_numero_if.sv
// Keypad-to-capture bus: key events in, captured BCD number and save strobe out.
// master = keypad/debouncer side, slave = captura_numero.
interface captura_numero_if #(
  parameter int NUM_DIGITOS = 4
);
  logic                               tecla_valida;
  logic [3:0]                         tecla;
  logic [NUM_DIGITOS-1:0][3:0]        numero;
  logic                               guardar;
  logic                               suma;
  logic [$clog2(NUM_DIGITOS+1)-1:0]   conteo;
  logic                               desborde;

  modport master (
    output tecla_valida, tecla,
    input  numero, guardar, suma, conteo, desborde
  );

  modport slave (
    input  tecla_valida, tecla,
    output numero, guardar, suma, conteo, desborde
  );
endinterface

// File: rtl/captura_numero.sv
// Shifts keypad digits into a packed BCD number and strobes guardar on '+'/'='.
// Optional idle auto-clear is built only when CAPTURA_TIMEOUT_EN is defined.
module captura_numero #(
  parameter int         NUM_DIGITOS    = 4,
  parameter logic [3:0] TECLA_SUMA     = 4'hA,
  parameter logic [3:0] TECLA_IGUAL    = 4'hB,
  parameter logic [3:0] TECLA_BORRAR   = 4'hC,
  parameter int         TIMEOUT_CICLOS = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  captura_numero_if.slave    bus
);
  localparam int CW = $clog2(NUM_DIGITOS + 1);

  typedef enum logic [1:0] {ESPERA, CAPTURA, LLENO, GUARDA} estado_t;

  estado_t                     estado_q, estado_d;
  logic [NUM_DIGITOS-1:0][3:0] numero_q, numero_d;
  logic [CW-1:0]               conteo_q, conteo_d;
  logic                        guardar_q, guardar_d;
  logic                        suma_q, suma_d;
  logic                        desborde_q, desborde_d;
  logic                        es_digito;
  logic                        timeout_fire;

  assign es_digito = (bus.tecla <= 4'd9);

`ifdef CAPTURA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  logic [TW-1:0] ocioso_q, ocioso_d;

  assign timeout_fire = ((estado_q == CAPTURA) || (estado_q == LLENO)) &&
                        (ocioso_q == TW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    ocioso_d = ocioso_q + 1'b1;
    if (bus.tecla_valida || timeout_fire ||
        (estado_q == ESPERA) || (estado_q == GUARDA)) begin
      ocioso_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ocioso_q <= '0;
    else      ocioso_q <= ocioso_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CICLOS;
  assign timeout_fire   = 1'b0;
`endif

  always_comb begin
    estado_d   = estado_q;
    numero_d   = numero_q;
    conteo_d   = conteo_q;
    desborde_d = desborde_q;
    guardar_d  = 1'b0;
    suma_d     = 1'b0;
    if (estado_q == GUARDA) begin
      // The strobe cycle swallows any key; the entry is always flushed afterwards.
      estado_d   = ESPERA;
      numero_d   = '0;
      conteo_d   = '0;
      desborde_d = 1'b0;
    end else if (bus.tecla_valida) begin
      if (es_digito) begin
        if (estado_q == LLENO) begin
          desborde_d = 1'b1;
        end else begin
          numero_d = {numero_q[NUM_DIGITOS-2:0], bus.tecla};
          conteo_d = conteo_q + 1'b1;
          estado_d = (conteo_q == CW'(NUM_DIGITOS - 1)) ? LLENO : CAPTURA;
        end
      end else if ((bus.tecla == TECLA_SUMA) || (bus.tecla == TECLA_IGUAL)) begin
        if (conteo_q != '0) begin
          estado_d  = GUARDA;
          guardar_d = 1'b1;
          suma_d    = (bus.tecla == TECLA_SUMA);
        end
      end else if (bus.tecla == TECLA_BORRAR) begin
        estado_d   = ESPERA;
        numero_d   = '0;
        conteo_d   = '0;
        desborde_d = 1'b0;
      end
    end else if (timeout_fire) begin
      estado_d   = ESPERA;
      numero_d   = '0;
      conteo_d   = '0;
      desborde_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q   <= ESPERA;
      numero_q   <= '0;
      conteo_q   <= '0;
      guardar_q  <= 1'b0;
      suma_q     <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      numero_q   <= numero_d;
      conteo_q   <= conteo_d;
      guardar_q  <= guardar_d;
      suma_q     <= suma_d;
      desborde_q <= desborde_d;
    end
  end

  assign bus.numero   = numero_q;
  assign bus.conteo   = conteo_q;
  assign bus.guardar  = guardar_q;
  assign bus.suma     = suma_q;
  assign bus.desborde = desborde_q;
endmodule
